// File: rtl/i2c_slave.sv
// ----------------------------------------------------------------------------
// i2c_slave : I2C target (responder), fixed 7-bit address, no clock stretching
//
// Oversamples SCL/SDA on clk, detects START / repeated START / STOP, ACKs its
// own address and every written byte, and fetches read bytes from user logic
// through a tx_req / tx_data handshake. SDA is only ever pulled low (open
// drain); SCL is never driven.
//
// Ports
//   clk       system clock (>= 8x SCL, >= 12x SCL with the glitch filter)
//   rst_n     asynchronous active-low reset
//   scl_in    raw bus SCL level
//   sda_in    raw bus SDA level
//   sda_oe    1 = pull SDA low, 0 = release
//   rx_data   last byte written by the master
//   rx_valid  one-clk pulse, rx_data is new
//   tx_data   next byte to send to the master
//   tx_req    one-clk pulse requesting the next tx_data
//   busy      high from address match until STOP or next START
//
// Build option
//   I2C_SLAVE_GLITCH_FILTER_EN : 3-sample majority filter on synchronised
//   SCL and SDA (rejects single-clk pulses, adds 2 clk of event latency).
// ----------------------------------------------------------------------------
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);
    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers. Reset to 1 so an idle (pulled-up) bus produces no
    // spurious edges when reset is released.
    // ------------------------------------------------------------------
    logic [NSYNC-1:0] r_scl_sync, r_sda_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[NSYNC-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[NSYNC-2:0], sda_in};
        end
    end

    logic w_scl, w_sda;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] r_scl_hist, r_sda_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_hist <= '1;
            r_sda_hist <= '1;
        end else begin
            r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[NSYNC-1]};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[NSYNC-1]};
        end
    end

    assign w_scl = (r_scl_hist[0] & r_scl_hist[1]) | (r_scl_hist[0] & r_scl_hist[2]) |
                   (r_scl_hist[1] & r_scl_hist[2]);
    assign w_sda = (r_sda_hist[0] & r_sda_hist[1]) | (r_sda_hist[0] & r_sda_hist[2]) |
                   (r_sda_hist[1] & r_sda_hist[2]);
`else
    assign w_scl = r_scl_sync[NSYNC-1];
    assign w_sda = r_sda_sync[NSYNC-1];
`endif

    logic r_scl_prev, r_sda_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    // START/STOP need SCL high on both samples, so an SDA change landing on
    // the same clk as an SCL edge is never mistaken for a bus condition.
    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    // ------------------------------------------------------------------
    // FSM + datapath registers
    // r_phase: in the ACK states, 0 = waiting for the fall that starts the
    // ACK bit, 1 = ACK bit in progress. In RD_ACK, 1 = master ACKed.
    // r_shift: address/write bits shift in at bit 0; read bits still to be
    // driven sit MSB-aligned. After the address byte, bit 0 holds R/W.
    // ------------------------------------------------------------------
    state_t     r_state, w_state_nx;
    logic [2:0] r_cnt, w_cnt_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic       r_phase, w_phase_nx;
    logic       r_sda_oe, w_oe_nx;
    logic [7:0] r_rx_data, w_rx_data_nx;
    logic       r_rx_valid, w_rx_valid_nx;
    logic       r_tx_req, w_tx_req_nx;
    logic       r_busy, w_busy_nx;
    logic       w_addr_hit;

    // General call (0x00) never matches, even if SLAVE_ADDR were set to 0.
    assign w_addr_hit = (r_shift[6:0] == SLAVE_ADDR) && (r_shift[6:0] != 7'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_shift    <= 8'h00;
            r_phase    <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_shift    <= w_shift_nx;
            r_phase    <= w_phase_nx;
            r_sda_oe   <= w_oe_nx;
            r_rx_data  <= w_rx_data_nx;
            r_rx_valid <= w_rx_valid_nx;
            r_tx_req   <= w_tx_req_nx;
            r_busy     <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_shift_nx    = r_shift;
        w_phase_nx    = r_phase;
        w_oe_nx       = r_sda_oe;
        w_rx_data_nx  = r_rx_data;
        w_rx_valid_nx = 1'b0;
        w_tx_req_nx   = 1'b0;
        w_busy_nx     = r_busy;

        if (w_stop) begin
            w_state_nx = IDLE;
            w_oe_nx    = 1'b0;
            w_busy_nx  = 1'b0;
        end else if (w_start) begin
            w_state_nx = ADDR;
            w_oe_nx    = 1'b0;
            w_busy_nx  = 1'b0;
            w_cnt_nx   = 3'd0;
            w_phase_nx = 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nx = {r_shift[6:0], w_sda};
                        w_cnt_nx   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (w_addr_hit) begin
                                w_state_nx  = ADDR_ACK;
                                w_busy_nx   = 1'b1;
                                w_phase_nx  = 1'b0;
                                w_tx_req_nx = w_sda;   // read: fetch first byte now
                            end else begin
                                w_state_nx = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_oe_nx    = 1'b1;
                            w_phase_nx = 1'b1;
                        end else begin
                            w_phase_nx = 1'b0;
                            if (r_shift[0]) begin
                                w_state_nx = RD_DATA;
                                w_shift_nx = {tx_data[6:0], 1'b0};
                                w_oe_nx    = ~tx_data[7];
                            end else begin
                                w_state_nx = WR_DATA;
                                w_oe_nx    = 1'b0;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    w_oe_nx = 1'b0;
                    if (w_scl_rise) begin
                        w_shift_nx = {r_shift[6:0], w_sda};
                        w_cnt_nx   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_rx_data_nx  = {r_shift[6:0], w_sda};
                            w_rx_valid_nx = 1'b1;
                            w_state_nx    = WR_ACK;
                            w_phase_nx    = 1'b0;
                        end
                    end
                end
                WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_oe_nx    = 1'b1;
                            w_phase_nx = 1'b1;
                        end else begin
                            w_oe_nx    = 1'b0;
                            w_phase_nx = 1'b0;
                            w_state_nx = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (w_scl_fall) begin
                        w_cnt_nx = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_oe_nx    = 1'b0;
                            w_state_nx = RD_ACK;
                            w_phase_nx = 1'b0;
                        end else begin
                            w_oe_nx    = ~r_shift[7];
                            w_shift_nx = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise && !r_phase) begin
                        if (!w_sda) begin
                            w_phase_nx  = 1'b1;
                            w_tx_req_nx = 1'b1;
                        end else begin
                            w_state_nx = WAIT_STOP;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        w_phase_nx = 1'b0;
                        w_state_nx = RD_DATA;
                        w_shift_nx = {tx_data[6:0], 1'b0};
                        w_oe_nx    = ~tx_data[7];
                    end
                end
                WAIT_STOP: w_oe_nx = 1'b0;
                default: w_state_nx = IDLE;
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave : bus-level master model driving i2c_slave, with a scoreboard.
// The master tasks push expected written bytes into exp_rx and byte sources
// into tx_src/exp_rd; an independent monitor pops them when the DUT pulses
// rx_valid / tx_req. Expected behaviour comes from plain rules: only
// SLAVE_ADDR is acknowledged, every matched write byte is ACKed and delivered,
// a read returns the served bytes in order with one tx_req per byte.
// ----------------------------------------------------------------------------
module tb_i2c_slave;
    localparam logic [6:0] ADDR = 7'h50;
    localparam int Q = 5;    // quarter SCL period in clks
    localparam int H = 10;   // SCL high time in clks

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data;
    logic       bus_sda;

    assign bus_sda = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(m_scl), .sda_in(bus_sda),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int tx_req_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_src[$];
    logic [7:0] exp_rd[$];
    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] last_rx = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (rx_valid) begin
                check("rx_valid_expected", 32'(exp_rx.size() > 0), 1);
                if (exp_rx.size() > 0) check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (tx_req) begin
                tx_req_cnt++;
                check("tx_req_expected", 32'(tx_src.size() > 0), 1);
                if (tx_src.size() > 0) tx_data = tx_src.pop_front();
            end
            if (rx_valid || tx_req) check("rx_tx_exclusive", rx_valid & tx_req, 0);
            if (sda_oe) oe_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        if (!m_scl) begin
            wclk(Q); m_sda = 1'b1; wclk(Q); m_scl = 1'b1;
        end
        wclk(Q); m_sda = 1'b0; wclk(H); m_scl = 1'b0;
        check("busy_after_start", busy, 0);
    endtask

    task automatic do_stop();
        wclk(Q); m_sda = 1'b0; wclk(Q); m_scl = 1'b1; wclk(Q); m_sda = 1'b1; wclk(H);
        check("busy_after_stop", busy, 0);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        wclk(Q); m_sda = b; wclk(Q); m_scl = 1'b1;
        wclk(H - 1); s = bus_sda; wclk(1); m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    function automatic logic model_hit(input logic [6:0] a);
        return (a == ADDR) && (a != 7'h00);
    endfunction

    task automatic wr_txn(input logic [6:0] a, input bit stop_f);
        logic ack, hit;
        logic [7:0] d;
        int oe0;
        hit = model_hit(a);
        oe0 = oe_cnt;
        do_start();
        send_byte({a, 1'b0}, ack);
        check("addr_ack_wr", ack, hit);
        check("busy_after_addr", busy, hit);
        while (wr_q.size() > 0) begin
            d = wr_q.pop_front();
            if (hit) begin
                exp_rx.push_back(d);
                last_rx = d;
            end
            send_byte(d, ack);
            check("data_ack", ack, hit);
        end
        if (!hit) check("no_sda_pull", oe_cnt - oe0, 0);
        if (stop_f) do_stop();
        check("rx_drained", exp_rx.size(), 0);
        check("rx_data_hold", rx_data, last_rx);
    endtask

    task automatic rd_txn(input logic [6:0] a);
        logic ack, hit, s;
        logic [7:0] got;
        int n, r0;
        hit = model_hit(a);
        n = rd_q.size();
        r0 = tx_req_cnt;
        while (rd_q.size() > 0) begin
            got = rd_q.pop_front();
            if (hit) begin
                tx_src.push_back(got);
                exp_rd.push_back(got);
            end
        end
        do_start();
        send_byte({a, 1'b1}, ack);
        check("addr_ack_rd", ack, hit);
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                got = 8'h00;
                for (int b = 0; b < 8; b++) begin
                    clock_bit(1'b1, s);
                    got = {got[6:0], s};
                end
                check("rd_data", got, exp_rd.pop_front());
                clock_bit((i == n - 1) ? 1'b1 : 1'b0, s);
            end
            wclk(4);
            check("sda_released_after_nack", sda_oe, 0);
        end
        do_stop();
        check("tx_req_count", tx_req_cnt - r0, hit ? n : 0);
        check("tx_src_drained", tx_src.size(), 0);
    endtask

    initial begin
        logic       s, ack;
        logic [6:0] ra;
        int         len;

        wclk(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        wclk(5);

        // Matched write of two bytes
        wr_q = '{8'hA5, 8'h3C};
        wr_txn(ADDR, 1'b1);

        // Address mismatch
        wr_q = '{8'hFF};
        wr_txn(7'h51, 1'b1);

        // General call is not supported
        wr_q = '{8'h12};
        wr_txn(7'h00, 1'b1);

        // Read: master ACKs first byte, NACKs second
        rd_q = '{8'h96, 8'h0F};
        rd_txn(ADDR);

        // Write, then repeated START into a read
        wr_q = '{8'h11};
        wr_txn(ADDR, 1'b0);
        rd_q = '{8'hC3};
        rd_txn(ADDR);

        // STOP in the middle of a byte discards it
        do_start();
        send_byte({ADDR, 1'b0}, ack);
        check("addr_ack_partial", ack, 1);
        for (int i = 0; i < 4; i++) clock_bit(i[0], s);
        do_stop();
        check("partial_rx_data_hold", rx_data, last_rx);
        wr_q = '{8'h5A};
        wr_txn(ADDR, 1'b1);

        // Asynchronous reset while the address ACK is being driven
        do_start();
        for (int i = 7; i >= 0; i--) clock_bit(((8'(ADDR) << 1) >> i) & 1, s);
        wclk(8);
        check("ack_driven_before_reset", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sda_oe", sda_oe, 0);
        check("async_rst_rx_data", rx_data, 0);
        check("async_rst_rx_valid", rx_valid, 0);
        check("async_rst_tx_req", tx_req, 0);
        check("async_rst_busy", busy, 0);
        last_rx = 8'h00;
        wclk(2);
        m_scl = 1'b1;
        m_sda = 1'b1;
        wclk(5);
        rst_n = 1'b1;
        wclk(10);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // Single-clk SDA low pulse with SCL high must not be taken as START
        m_sda = 1'b0;
        wclk(1);
        m_sda = 1'b1;
        wclk(H);
        m_scl = 1'b0;
        send_byte({ADDR, 1'b0}, ack);
        check("glitch_no_start_ack", ack, 0);
        check("glitch_busy", busy, 0);
        do_stop();
`endif

        // Randomised transactions
        for (int t = 0; t < 20; t++) begin
            ra  = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
            len = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < len; i++) wr_q.push_back(8'($urandom));
                wr_txn(ra, 1'b1);
            end else begin
                for (int i = 0; i < len; i++) rd_q.push_back(8'($urandom));
                rd_txn(ra);
            end
        end

        wclk(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the opposite end of the bus from the team's I2C master.
- Oversamples the SCL and SDA pins on the system clock and detects START, STOP and repeated START.
- Matches a fixed 7-bit address, ACKs and delivers written bytes, and fetches read bytes from user logic through a request/data handshake.
- Drives SDA open-drain only (pull-low enable); never drives SCL; no clock stretching.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must be >= 8x SCL frequency.
- rst_n  input  1  reset.
- scl_in  input  1  raw bus SCL level.
- sda_in  input  1  raw bus SDA level.
- sda_oe  output  1  1 = pull SDA low; 0 = release. Top level does sda = sda_oe ? 0 : z.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse; rx_data is new.
- tx_data  input  8  next byte to send to the master.
- tx_req  output  1  one-clk pulse requesting the next tx_data.
- busy  output  1  high from address match until STOP or next START.

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, FSM=IDLE.
- SCL/SDA pass through SYNC_STAGES flops; one extra register provides previous levels for edge detection.
- Events, computed on synchronised signals:
  - scl_rise / scl_fall: edges of SCL.
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
- Data bit handling:
  - Bits are sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall, except on START/STOP.
- Bit counter: 3 bits, wraps 7->0 after each byte; cleared on START.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- State transitions:
  - IDLE: START -> ADDR.
  - ADDR: shift 8 bits (7 address bits + R/W). After the 8th scl_rise:
    - address equal to SLAVE_ADDR -> ADDR_ACK, busy=1;
    - otherwise -> WAIT_STOP.
  - ADDR_ACK:
    - On the scl_fall after the 8th bit, assert sda_oe=1 (ACK).
    - On the next scl_fall, go to WR_DATA (R/W=0) or RD_DATA (R/W=1).
    - For a read, tx_req pulses one clk after the 8th address bit's scl_rise.
    - tx_data is loaded into the shift register on the scl_fall that ends ADDR_ACK; its MSB drives sda_oe = ~bit at that same edge.
  - WR_DATA:
    - sda_oe=0; shift 8 bits.
    - After the 8th scl_rise: rx_data <= byte, rx_valid pulses for 1 clk -> WR_ACK.
  - WR_ACK: always ACK (sda_oe=1 for one SCL bit), then return to WR_DATA.
  - RD_DATA:
    - Shift out on each scl_fall; sda_oe = ~current bit.
    - After the 8th bit's scl_fall, release SDA -> RD_ACK.
  - RD_ACK: sample the master's bit on scl_rise.
    - 0 (ACK): tx_req pulses 1 clk later; new tx_data is loaded at the next scl_fall -> RD_DATA.
    - 1 (NACK): -> WAIT_STOP with SDA released.
  - WAIT_STOP: sda_oe=0; ignore traffic until START or STOP.
- START (including repeated START) in any state: sda_oe=0, busy=0, bit counter cleared -> ADDR. A partially received byte is discarded with no rx_valid.
- STOP in any state: sda_oe=0, busy=0 -> IDLE.
- START/STOP detection takes priority over a same-cycle SCL edge.
- rx_valid and tx_req never assert in the same clk.
- General-call address 0x00 is not supported and is treated as a mismatch.
- Asynchronous reset mid-transfer releases SDA immediately.

Optional Feature:
- Macro I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after synchronisation, SCL and SDA each pass a 3-sample majority filter, so single-clk pulses are rejected. This adds 2 clk of latency to all events and raises the clk requirement to >= 12x SCL.
- Undefined: no filter; events follow the synchronised levels directly.

Test Plan:
- Write to 0x50 with bytes 0xA5, 0x3C, then STOP -> ACK on the address and on both bytes; rx_valid pulses twice with rx_data=0xA5 then 0x3C; busy falls at STOP.
- Write to 0x51 with 0xFF -> SDA never pulled low; no rx_valid; busy stays 0; FSM returns to IDLE on STOP.
- Read from 0x50 with tx_data=0x96, then 0x0F; master ACKs the first byte and NACKs the second -> SDA carries 1001_0110 then 0000_1111; tx_req pulses exactly twice; SDA released after the NACK.
- Write 0x50 + 0x11, then repeated START + read 0x50 with tx_data=0xC3 -> rx_valid for 0x11; repeated START returns the FSM to ADDR; 0xC3 is read back correctly.
- STOP after 4 bits of a write byte, then a new write of 0x5A -> no rx_valid for the partial byte; 0x5A is received correctly.
- rst_n asserted while sda_oe=1 during an ACK -> sda_oe=0 asynchronously; all outputs at reset values. With I2C_SLAVE_GLITCH_FILTER_EN, a 1-clk SDA low pulse while SCL=1 -> no START detected.
